fb_write_arbiter: RTL and testbench
===================================

# fb_write_arbiter

Arbitrates the single framebuffer SRAM port between the rasterizer's pixel-write stream and the VGA scan-out read stream. Rasterizer pixels (x, y, color) enter a small FIFO, which provides back-pressure via `oPIX_READY`. VGA reads always win, and writes drain into idle and blanking slots. The block sits between the edge rasterizer output and the SRAM controller, and replaces direct registration of rasterizer outputs onto `oMEM_*`.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: pixel FIFO entries; must be a power of 2, at least 2.
- `ADDR_W`, default 18: SRAM word-address width.
- `DATA_W`, default 16: SRAM data and color width.
- `SCREEN_W`, default 640: pixels per row, used in address generation.
- `SCREEN_H`, default 480: rows; used only when clipping is enabled.

Ports:
- `iCLK` in, 1: the single clock; all logic is on the rising edge.
- `iRST` in, 1: synchronous, active-high reset.
- `iPIX_VALID` in, 1: a rasterizer pixel is offered.
- `iPIX_X` in, 16: pixel x coordinate.
- `iPIX_Y` in, 16: pixel y coordinate.
- `iPIX_COLOR` in, `DATA_W`: pixel color.
- `oPIX_READY` out, 1: FIFO can accept; a push occurs when `iPIX_VALID & oPIX_READY`.
- `iVIDEO_ON` in, 1: VGA active region.
- `iVGA_REQ` in, 1: VGA read request this cycle.
- `iVGA_ADDR` in, `ADDR_W`: VGA read address.
- `oVGA_DATA` out, `DATA_W`: read data returned to VGA.
- `oVGA_VALID` out, 1: one-cycle strobe marking `oVGA_DATA` valid.
- `iGPU_DATA` in, `DATA_W`: SRAM read data.
- `oGPU_DATA` out, `DATA_W`: SRAM write data.
- `oMEM_ADDR` out, `ADDR_W`: SRAM address.
- `oMEM_WRITE` out, 1: SRAM write strobe.
- `oMEM_READ` out, 1: SRAM read strobe.
- `oFIFO_EMPTY` out, 1: no pixels pending; the sequencer uses this to end a draw.

## Operation
- **Write address:** computed at push as `iPIX_Y*SCREEN_W + iPIX_X`, truncated to `ADDR_W` bits. The FIFO stores the address and color.
- **FIFO:** `FIFO_DEPTH` entries; pointers wrap modulo depth; occupancy counter is `log2(FIFO_DEPTH)+1` bits.
  - `oPIX_READY = (count != FIFO_DEPTH)`.
  - `oFIFO_EMPTY = (count == 0)`.
  - Push and pop in the same cycle leave `count` unchanged.
- **States:**
  - **IDLE:** bus idle.
    - `iVIDEO_ON & iVGA_REQ` → READ.
    - Else `!empty` → WRITE.
    - Else stay in IDLE.
  - **READ:** `oMEM_READ=1`, `oMEM_ADDR` = latched `iVGA_ADDR`.
    - Another VGA request → READ, back-to-back.
    - Else `!empty` → WRITE.
    - Else → IDLE.
  - **WRITE:** `oMEM_WRITE=1`, address and data from the FIFO head; pops one entry.
    - VGA request → TURN.
    - Else `count>1`, or a push this cycle → WRITE.
    - Else → IDLE.
  - **TURN:** one-cycle bus turnaround, no strobes; always → READ if a request is pending, else IDLE.
- **Request handling:**
  - A VGA request arriving during WRITE is held in a one-deep pending register and is serviced after TURN.
  - `iVGA_REQ` with `iVIDEO_ON=0` is ignored.
- **Read data:** `iGPU_DATA` is sampled the cycle after READ into `oVGA_DATA`, with `oVGA_VALID=1` for one cycle.

## Timing
- All outputs are registered except `oPIX_READY` and `oFIFO_EMPTY`, which decode the registered count.
- **Reset values** (`iRST` high at an edge): state IDLE, FIFO flushed (count 0), pending request cleared, all `oMEM_*`, `oGPU_DATA`, `oVGA_DATA`, and `oVGA_VALID` = 0, `oPIX_READY=1`, `oFIFO_EMPTY=1`. Reset mid-write discards all queued pixels.
- **Push-to-write latency:** a pixel pushed at edge k into an empty FIFO with no VGA request appears on `oMEM_WRITE` at edge k+2.
- **Read latency:** a VGA request sampled at edge k gives `oMEM_READ` at k+1 and `oVGA_VALID` at k+2. From WRITE, TURN adds one cycle.
- **Priority:** VGA always wins. During the active region, writes occur only in cycles with no request. Write starvation during continuous reads is permitted.
- **Full FIFO:** `oPIX_READY=0`; pushes are refused even if a pop occurs in the same cycle.
- **Empty FIFO:** a push is not visible to the arbiter until the next cycle.

## Configuration
- **`FB_CLIP_EN` defined:** pixels with `x >= SCREEN_W` or `y >= SCREEN_H` are accepted (the handshake completes) but discarded, never entering the FIFO.
- **`FB_CLIP_EN` not defined:** every accepted pixel is written at its truncated address, so out-of-range coordinates alias.

## Test plan
- Reset, then push (x=25, y=100, color=16'h0F00) with `iVIDEO_ON=0` → one `oMEM_WRITE` with address 64025, data 16'h0F00, two cycles after the push; `oFIFO_EMPTY` returns to 1.
- Push 10 pixels back-to-back with `FIFO_DEPTH=8` while `iVIDEO_ON=1` and `iVGA_REQ=1` continuously → `oPIX_READY` drops after 8 pushes; no writes occur; every read returns `oVGA_VALID` two cycles after its request.
- Drop `iVGA_REQ` while 8 pixels are queued → 8 consecutive write cycles in FIFO order, then IDLE.
- Assert `iVGA_REQ` during a WRITE → one TURN cycle with no strobes, then READ at the held address.
- Push x=700, y=10 → with `FB_CLIP_EN`: accepted, no write. Without: write at address 7100.
- Assert `iRST` with 5 pixels queued → next cycle `count=0`, `oPIX_READY=1`, no further writes.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Framebuffer SRAM port arbiter: VGA reads win, queued pixel writes fill idle slots.
// Optional FB_CLIP_EN: drop off-screen pixels at the FIFO input.
module fb_write_arbiter #(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 18,
   parameter int DATA_W     = 16,
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iPIX_VALID,
   input  logic [15:0]       iPIX_X,
   input  logic [15:0]       iPIX_Y,
   input  logic [DATA_W-1:0] iPIX_COLOR,
   output logic              oPIX_READY,
   input  logic              iVIDEO_ON,
   input  logic              iVGA_REQ,
   input  logic [ADDR_W-1:0] iVGA_ADDR,
   output logic [DATA_W-1:0] oVGA_DATA,
   output logic              oVGA_VALID,
   input  logic [DATA_W-1:0] iGPU_DATA,
   output logic [DATA_W-1:0] oGPU_DATA,
   output logic [ADDR_W-1:0] oMEM_ADDR,
   output logic              oMEM_WRITE,
   output logic              oMEM_READ,
   output logic              oFIFO_EMPTY
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SCREEN_H < 1)
   begin : g_cfg_err
      $error("fb_write_arbiter: invalid parameters");
   end

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_TURN} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr_mem  [FIFO_DEPTH];
   logic [DATA_W-1:0] color_mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;
   logic [ADDR_W-1:0] pix_addr;
   logic              push, fifo_push, pop, empty, req, pending;
   logic [ADDR_W-1:0] vga_addr;
   logic              mem_write_d, mem_read_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] gpu_data_d;

   assign pix_addr = ADDR_W'({16'd0, iPIX_Y} * SCREEN_W[31:0] + {16'd0, iPIX_X});
   assign empty       = (count == '0);
   assign oPIX_READY  = (count != FULL);
   assign oFIFO_EMPTY = empty;
   assign push        = iPIX_VALID & oPIX_READY;
   assign req         = iVIDEO_ON & iVGA_REQ;
   assign pop         = (state == S_WRITE) && !empty;

`ifdef FB_CLIP_EN
   logic in_range;
   assign in_range  = ({16'd0, iPIX_X} < SCREEN_W[31:0]) &&
                      ({16'd0, iPIX_Y} < SCREEN_H[31:0]);
   assign fifo_push = push & in_range;
`else
   assign fifo_push = push;
`endif

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)       rd_ptr <= rd_ptr + 1'b1;
         case ({fifo_push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge iCLK) begin
      if (fifo_push) begin
         addr_mem[wr_ptr]  <= pix_addr;
         color_mem[wr_ptr] <= iPIX_COLOR;
      end
   end

   // Latest accepted VGA address; a request seen during WRITE waits out TURN.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         vga_addr <= '0;
         pending  <= 1'b0;
      end else begin
         if (req) vga_addr <= iVGA_ADDR;
         if (state == S_WRITE && req) pending <= 1'b1;
         else if (state == S_TURN)    pending <= 1'b0;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_READ: begin
            if (req)         state_nx = S_READ;
            else if (!empty) state_nx = S_WRITE;
            else             state_nx = S_IDLE;
         end
         S_WRITE: begin
            if (req)                          state_nx = S_TURN;
            else if (count > 1 || fifo_push)  state_nx = S_WRITE;
            else                              state_nx = S_IDLE;
         end
         S_TURN: begin
            if (pending || req) state_nx = S_READ;
            else                state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      mem_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_addr_d  = '0;
      gpu_data_d  = '0;
      case (state)
         S_READ: begin
            mem_read_d = 1'b1;
            mem_addr_d = vga_addr;
         end
         S_WRITE: begin
            mem_write_d = !empty;
            mem_addr_d  = addr_mem[rd_ptr];
            gpu_data_d  = color_mem[rd_ptr];
         end
         default: ;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         oMEM_WRITE <= 1'b0;
         oMEM_READ  <= 1'b0;
         oMEM_ADDR  <= '0;
         oGPU_DATA  <= '0;
         oVGA_VALID <= 1'b0;
         oVGA_DATA  <= '0;
      end else begin
         oMEM_WRITE <= mem_write_d;
         oMEM_READ  <= mem_read_d;
         oMEM_ADDR  <= mem_addr_d;
         oGPU_DATA  <= gpu_data_d;
         oVGA_VALID <= oMEM_READ;
         if (oMEM_READ) oVGA_DATA <= iGPU_DATA;
      end
   end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter with a simple SRAM read-data model.
// Expected values are hand computed from the pixel/address vectors.
module tb_fb_write_arbiter;

   logic        clk, rst;
   logic        pix_valid;
   logic [15:0] pix_x, pix_y, pix_color;
   logic        pix_ready;
   logic        video_on, vga_req;
   logic [17:0] vga_addr;
   logic [15:0] vga_data;
   logic        vga_valid;
   logic [15:0] gpu_rdata, gpu_wdata;
   logic [17:0] mem_addr;
   logic        mem_write, mem_read, fifo_empty;

   int n_chk  = 0;
   int n_pass = 0;

   fb_write_arbiter dut (
      .iCLK        (clk),
      .iRST        (rst),
      .iPIX_VALID  (pix_valid),
      .iPIX_X      (pix_x),
      .iPIX_Y      (pix_y),
      .iPIX_COLOR  (pix_color),
      .oPIX_READY  (pix_ready),
      .iVIDEO_ON   (video_on),
      .iVGA_REQ    (vga_req),
      .iVGA_ADDR   (vga_addr),
      .oVGA_DATA   (vga_data),
      .oVGA_VALID  (vga_valid),
      .iGPU_DATA   (gpu_rdata),
      .oGPU_DATA   (gpu_wdata),
      .oMEM_ADDR   (mem_addr),
      .oMEM_WRITE  (mem_write),
      .oMEM_READ   (mem_read),
      .oFIFO_EMPTY (fifo_empty)
   );

   // SRAM model: read data is the address scrambled with a fixed pattern
   assign gpu_rdata = mem_read ? (mem_addr[15:0] ^ 16'hA5A5) : 16'hDEAD;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic set_pix(input logic v, input int x, input int y,
                          input logic [15:0] c);
      pix_valid = v;
      pix_x     = 16'(x);
      pix_y     = 16'(y);
      pix_color = c;
   endtask

   initial begin
      rst = 1'b1;
      set_pix(1'b0, 0, 0, 16'h0);
      video_on = 1'b0;
      vga_req  = 1'b0;
      vga_addr = '0;
      tick();
      tick();
      check("rst_wr",    mem_write, 0);
      check("rst_rd",    mem_read, 0);
      check("rst_addr",  mem_addr, 0);
      check("rst_wdata", gpu_wdata, 0);
      check("rst_vv",    vga_valid, 0);
      check("rst_vdata", vga_data, 0);
      check("rst_ready", pix_ready, 1);
      check("rst_empty", fifo_empty, 1);
      rst = 1'b0;
      tick();

      // single pixel, blanking: write two edges after push
      set_pix(1'b1, 25, 100, 16'h0F00);
      tick();
      set_pix(1'b0, 0, 0, 16'h0);
      check("p1_empty0", fifo_empty, 0);
      check("p1_nowr0",  mem_write, 0);
      tick();
      check("p1_nowr1",  mem_write, 0);
      tick();
      check("p1_wr",     mem_write, 1);
      check("p1_addr",   mem_addr, 64025);
      check("p1_data",   gpu_wdata, 16'h0F00);
      check("p1_empty1", fifo_empty, 1);
      tick();
      check("p1_once",   mem_write, 0);

      // continuous reads while 10 pixels are offered
      video_on = 1'b1;
      for (int i = 0; i < 10; i++) begin
         vga_req  = 1'b1;
         vga_addr = 18'(100 + i);
         set_pix(1'b1, 3 * i, 2, 16'(16'hC000 + i));
         check("fill_ready", pix_ready, (i < 8) ? 1 : 0);
         tick();
         check("fill_nowr", mem_write, 0);
         if (i >= 1) begin
            check("fill_rd",    mem_read, 1);
            check("fill_raddr", mem_addr, 100 + i - 1);
         end
         if (i >= 2) begin
            check("fill_vv",    vga_valid, 1);
            check("fill_vdata", vga_data, (100 + i - 2) ^ 16'hA5A5);
         end
      end

      // requests stop: drain 8 writes in order
      vga_req = 1'b0;
      set_pix(1'b0, 0, 0, 16'h0);
      tick();
      check("drain_lastrd", mem_read, 1);
      check("drain_raddr",  mem_addr, 109);
      check("drain_nowr",   mem_write, 0);
      for (int j = 0; j < 8; j++) begin
         tick();
         check("drain_wr",   mem_write, 1);
         check("drain_addr", mem_addr, 1280 + 3 * j);
         check("drain_data", gpu_wdata, 16'hC000 + j);
         if (j == 0) begin
            check("drain_vv",    vga_valid, 1);
            check("drain_vdata", vga_data, 109 ^ 16'hA5A5);
         end
      end
      tick();
      check("drain_end",   mem_write, 0);
      check("drain_empty", fifo_empty, 1);

      // VGA request during WRITE: TURN then READ at held address
      set_pix(1'b1, 5, 1, 16'h3333);
      tick();
      set_pix(1'b0, 0, 0, 16'h0);
      tick();
      check("turn_prewr", mem_write, 0);
      vga_req  = 1'b1;
      vga_addr = 18'h1234;
      tick();
      vga_req  = 1'b0;
      vga_addr = 18'h0;
      check("turn_wr",    mem_write, 1);
      check("turn_waddr", mem_addr, 645);
      check("turn_wdata", gpu_wdata, 16'h3333);
      tick();
      check("turn_nowr",  mem_write, 0);
      check("turn_nord",  mem_read, 0);
      tick();
      check("turn_rd",    mem_read, 1);
      check("turn_raddr", mem_addr, 18'h1234);
      tick();
      check("turn_vv",    vga_valid, 1);
      check("turn_vdata", vga_data, 16'h1234 ^ 16'hA5A5);
      tick();
      check("turn_vv_off", vga_valid, 0);

      // off-screen pixel
      video_on = 1'b0;
      set_pix(1'b1, 700, 10, 16'h7777);
      check("clip_ready", pix_ready, 1);
      tick();
      set_pix(1'b0, 0, 0, 16'h0);
`ifdef FB_CLIP_EN
      check("clip_empty", fifo_empty, 1);
      tick();
      tick();
      check("clip_nowr",  mem_write, 0);
`else
      check("clip_empty", fifo_empty, 0);
      tick();
      tick();
      check("clip_wr",    mem_write, 1);
      check("clip_addr",  mem_addr, 7100);
      check("clip_data",  gpu_wdata, 16'h7777);
`endif
      tick();

      // reset with 5 pixels queued behind continuous reads
      video_on = 1'b1;
      vga_req  = 1'b1;
      vga_addr = 18'd50;
      for (int i = 0; i < 5; i++) begin
         set_pix(1'b1, i, 0, 16'(16'h5000 + i));
         tick();
      end
      set_pix(1'b0, 0, 0, 16'h0);
      check("q5_empty", fifo_empty, 0);
      check("q5_nowr",  mem_write, 0);
      rst     = 1'b1;
      vga_req = 1'b0;
      tick();
      check("mrst_empty", fifo_empty, 1);
      check("mrst_ready", pix_ready, 1);
      check("mrst_wr",    mem_write, 0);
      check("mrst_rd",    mem_read, 0);
      check("mrst_vv",    vga_valid, 0);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("mrst_nowr",  mem_write, 0);
         check("mrst_still", fifo_empty, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
